// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared definitions for the program-counter sequencer and any decoder that
// needs to produce its mode selects: next-PC mode encodings and the
// increment-size table.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_INC    = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_CALL   = 3'd4,
        SEL_RET    = 3'd5
    } pc_sel_e;

    localparam int STEP_W = 4;

    // step_sel 0..3 selects an increment of 1, 2, 4 or 8
    function automatic logic [STEP_W-1:0] step_value(input logic [1:0] step_sel);
        logic [STEP_W-1:0] s;
        case (step_sel)
            2'd0:    s = 4'd1;
            2'd1:    s = 4'd2;
            2'd2:    s = 4'd4;
            default: s = 4'd8;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// ret_stack
// Circular return-address stack. A push into a full stack overwrites the
// oldest entry and sets the sticky ovf flag; a pop from an empty stack
// leaves everything unchanged and sets the sticky udf flag.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push, pop   one-cycle strobes (never both high together)
//   push_data   address pushed on push
//   top         most recently pushed entry (valid when depth > 0)
//   depth       occupancy, 0..DEPTH
//   ovf, udf    sticky overflow / underflow flags
module ret_stack #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       ovf,
    output logic                       udf
);

    localparam int SPW = $clog2(DEPTH);
    localparam int DW  = SPW + 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp;   // next slot to write
    logic [SPW-1:0]   top_idx;

    assign top_idx = sp - SPW'(1);
    assign top     = mem[top_idx];

    // Contents are not reset; they are unreachable while depth is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            depth <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (push) begin
            sp <= sp + SPW'(1);
            if (depth == FULL) begin
                ovf <= 1'b1;
            end else begin
                depth <= depth + DW'(1);
            end
        end else if (pop) begin
            if (depth == '0) begin
                udf <= 1'b1;
            end else begin
                sp    <= top_idx;
                depth <= depth - DW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer with hold/increment/branch/jump/call/return
// modes and a circular return-address stack.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en, stall    advance only when en=1 and stall=0
//   sel          next-PC mode (pc_sel_e; 6/7 behave as HOLD)
//   step_sel     increment size 1/2/4/8
//   offset       two's-complement branch displacement
//   target       absolute jump/call address
//   pc           registered current PC
//   pc_next      combinational value pc takes at the next qualifying edge
//   depth        return-stack occupancy
//   ovf, udf     sticky stack overflow / underflow flags
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH        = 17,
    parameter int               DEPTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   stall,
    input  logic [2:0]             sel,
    input  logic [1:0]             step_sel,
    input  logic [WIDTH-1:0]       offset,
    input  logic [WIDTH-1:0]       target,
    output logic [WIDTH-1:0]       pc,
    output logic [WIDTH-1:0]       pc_next,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   ovf,
    output logic                   udf
);

    logic             advance;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] stack_top;

    assign advance = en & ~stall;
    assign push    = advance && (sel == SEL_CALL);
    assign pop     = advance && (sel == SEL_RET);
    assign step    = WIDTH'(step_value(step_sel));
    assign pc_inc  = pc + step;

    // All sums are WIDTH bits wide, so carries out of the top bit drop off.
    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_INC:    pc_next = pc_inc;
            SEL_BRANCH: pc_next = pc_inc + offset;
            SEL_JUMP:   pc_next = target;
            SEL_CALL:   pc_next = target;
            SEL_RET:    pc_next = (depth == '0) ? pc_inc : stack_top;
            default:    pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else if (advance) begin
            pc <= pc_next;
        end
    end

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stack_top),
        .depth     (depth),
        .ovf       (ovf),
        .udf       (udf)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int WIDTH = 17;
    localparam int DEPTH = 4;

    localparam logic [2:0] HOLD   = 3'd0;
    localparam logic [2:0] INC    = 3'd1;
    localparam logic [2:0] BRANCH = 3'd2;
    localparam logic [2:0] JUMP   = 3'd3;
    localparam logic [2:0] CALL   = 3'd4;
    localparam logic [2:0] RET    = 3'd5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             stall = 1'b0;
    logic [2:0]       sel = 3'd0;
    logic [1:0]       step_sel = 2'd0;
    logic [WIDTH-1:0] offset = '0;
    logic [WIDTH-1:0] target = '0;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic [2:0]       depth;
    logic             ovf;
    logic             udf;

    int vectors = 0;
    int miscompares = 0;

    pc_sequencer #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .RESET_VECTOR (17'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .stall    (stall),
        .sel      (sel),
        .step_sel (step_sel),
        .offset   (offset),
        .target   (target),
        .pc       (pc),
        .pc_next  (pc_next),
        .depth    (depth),
        .ovf      (ovf),
        .udf      (udf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [1:0] ss,
                         input logic [WIDTH-1:0] off, input logic [WIDTH-1:0] tgt);
        sel = s;
        step_sel = ss;
        offset = off;
        target = tgt;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        en = 1'b1;
        stall = 1'b0;
        drive(HOLD, 2'd0, '0, '0);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (pc !== 17'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc, 17'h0); end
        vectors++;
        if (depth !== 3'd0) begin miscompares++; $display("FAIL reset_depth got %0d want 0", depth); end
        vectors++;
        if ({ovf, udf} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b want 00", {ovf, udf}); end
    endtask

    task automatic test_inc();
        logic [WIDTH-1:0] exp_pc [3];
        exp_pc[0] = 17'h2; exp_pc[1] = 17'h4; exp_pc[2] = 17'h6;
        do_reset();
        drive(INC, 2'd1, '0, '0);
        #1;
        vectors++;
        if (pc_next !== 17'h2) begin miscompares++; $display("FAIL inc_pc_next got %h want %h", pc_next, 17'h2); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (pc !== exp_pc[i]) begin miscompares++; $display("FAIL inc_pc[%0d] got %h want %h", i, pc, exp_pc[i]); end
        end
        // en=0: pc holds, pc_next still follows inputs
        en = 1'b0;
        drive(INC, 2'd3, '0, '0);
        tick();
        vectors++;
        if (pc !== 17'h6) begin miscompares++; $display("FAIL en_low_hold got %h want %h", pc, 17'h6); end
        vectors++;
        if (pc_next !== 17'hE) begin miscompares++; $display("FAIL en_low_pc_next got %h want %h", pc_next, 17'hE); end
        en = 1'b1;
        drive(3'd6, 2'd3, '0, 17'h1234);
        tick();
        vectors++;
        if (pc !== 17'h6) begin miscompares++; $display("FAIL sel6_hold got %h want %h", pc, 17'h6); end
    endtask

    task automatic test_wrap();
        drive(JUMP, 2'd0, '0, 17'h1FFFE);
        tick();
        vectors++;
        if (pc !== 17'h1FFFE) begin miscompares++; $display("FAIL jump_pc got %h want %h", pc, 17'h1FFFE); end
        drive(INC, 2'd2, '0, '0);
        tick();
        vectors++;
        if (pc !== 17'h00002) begin miscompares++; $display("FAIL wrap_pc got %h want %h", pc, 17'h00002); end
    endtask

    task automatic test_branch();
        drive(JUMP, 2'd0, '0, 17'h100);
        tick();
        drive(BRANCH, 2'd0, 17'h1FFF0, '0);
        tick();
        vectors++;
        if (pc !== 17'h0F1) begin miscompares++; $display("FAIL branch_back got %h want %h", pc, 17'h0F1); end
        drive(BRANCH, 2'd1, 17'h00010, '0);
        tick();
        vectors++;
        if (pc !== 17'h103) begin miscompares++; $display("FAIL branch_fwd got %h want %h", pc, 17'h103); end
        drive(INC, 2'd3, '0, '0);
        tick();
        vectors++;
        if (pc !== 17'h10B) begin miscompares++; $display("FAIL inc8 got %h want %h", pc, 17'h10B); end
    endtask

    task automatic test_call_ret();
        do_reset();
        drive(JUMP, 2'd0, '0, 17'h10);
        tick();
        drive(CALL, 2'd2, '0, 17'h40);
        tick();
        vectors++;
        if (pc !== 17'h40) begin miscompares++; $display("FAIL call_pc got %h want %h", pc, 17'h40); end
        vectors++;
        if (depth !== 3'd1) begin miscompares++; $display("FAIL call_depth got %0d want 1", depth); end
        drive(RET, 2'd2, '0, '0);
        #1;
        vectors++;
        if (pc_next !== 17'h14) begin miscompares++; $display("FAIL ret_pc_next got %h want %h", pc_next, 17'h14); end
        tick();
        vectors++;
        if (pc !== 17'h14) begin miscompares++; $display("FAIL ret_pc got %h want %h", pc, 17'h14); end
        vectors++;
        if (depth !== 3'd0) begin miscompares++; $display("FAIL ret_depth got %0d want 0", depth); end
    endtask

    task automatic test_overflow_underflow();
        logic [WIDTH-1:0] tgt [5];
        logic [WIDTH-1:0] ret_pc [4];
        tgt[0] = 17'h100; tgt[1] = 17'h200; tgt[2] = 17'h300; tgt[3] = 17'h400; tgt[4] = 17'h500;
        ret_pc[0] = 17'h401; ret_pc[1] = 17'h301; ret_pc[2] = 17'h201; ret_pc[3] = 17'h101;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(CALL, 2'd0, '0, tgt[i]);
            tick();
            if (i == 3) begin
                vectors++;
                if ({depth, ovf} !== {3'd4, 1'b0}) begin miscompares++; $display("FAIL full_no_ovf got depth %0d ovf %b want 4 0", depth, ovf); end
            end
        end
        vectors++;
        if (depth !== 3'd4) begin miscompares++; $display("FAIL ovf_depth got %0d want 4", depth); end
        vectors++;
        if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", ovf); end
        for (int i = 0; i < 4; i++) begin
            drive(RET, 2'd0, '0, '0);
            tick();
            vectors++;
            if (pc !== ret_pc[i]) begin miscompares++; $display("FAIL ret_pc[%0d] got %h want %h", i, pc, ret_pc[i]); end
            vectors++;
            if (depth !== 3'(3 - i)) begin miscompares++; $display("FAIL ret_depth[%0d] got %0d want %0d", i, depth, 3 - i); end
        end
        vectors++;
        if (udf !== 1'b0) begin miscompares++; $display("FAIL udf_early got %b want 0", udf); end
        drive(RET, 2'd0, '0, '0);
        tick();
        vectors++;
        if (pc !== 17'h102) begin miscompares++; $display("FAIL udf_pc got %h want %h", pc, 17'h102); end
        vectors++;
        if ({udf, depth} !== {1'b1, 3'd0}) begin miscompares++; $display("FAIL udf_flag got udf %b depth %0d want 1 0", udf, depth); end
        drive(INC, 2'd0, '0, '0);
        tick();
        vectors++;
        if ({ovf, udf} !== 2'b11) begin miscompares++; $display("FAIL sticky_flags got %b want 11", {ovf, udf}); end
    endtask

    task automatic test_stall_reset();
        do_reset();
        drive(JUMP, 2'd0, '0, 17'h10);
        tick();
        stall = 1'b1;
        drive(CALL, 2'd2, '0, 17'h40);
        tick();
        vectors++;
        if ({pc, depth} !== {17'h10, 3'd0}) begin miscompares++; $display("FAIL stall_hold got pc %h depth %0d want 10 0", pc, depth); end
        vectors++;
        if (pc_next !== 17'h40) begin miscompares++; $display("FAIL stall_pc_next got %h want %h", pc_next, 17'h40); end
        stall = 1'b0;
        tick();
        vectors++;
        if ({pc, depth} !== {17'h40, 3'd1}) begin miscompares++; $display("FAIL unstall_call got pc %h depth %0d want 40 1", pc, depth); end
        drive(RET, 2'd2, '0, '0);
        tick();
        tick();
        vectors++;
        if (udf !== 1'b1) begin miscompares++; $display("FAIL pre_reset_udf got %b want 1", udf); end
        // async reset mid-call, checked before any clock edge
        drive(CALL, 2'd0, '0, 17'h77);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({pc, depth, ovf, udf} !== {17'h0, 3'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset got pc %h depth %0d ovf %b udf %b want 0 0 0 0", pc, depth, ovf, udf);
        end
        #1;
        rst = 1'b0;
        drive(INC, 2'd0, '0, '0);
        tick();
        vectors++;
        if ({pc, depth} !== {17'h1, 3'd0}) begin miscompares++; $display("FAIL post_reset_inc got pc %h depth %0d want 1 0", pc, depth); end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_wrap();
        test_branch();
        test_call_ret();
        test_overflow_underflow();
        test_stall_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
